freq_generator: RTL and testbench
=================================

FREQ_GENERATOR -- requirements
Module: freq_generator

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 16, width of period, count and status buses.
REQ-002 SHALL have port: Clock  input  1  single system clock; all state updates on posedge Clock.
REQ-003 SHALL have port: nReset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: enable  input  1  global clock-enable; when low all state, counters and outputs SHALL hold.
REQ-005 SHALL have port: start  input  1  level request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port: abort  input  1  synchronous cancel of a burst in progress.
REQ-007 SHALL have port: half_period  input  DATA_WIDTH  Clock cycles per high phase and per low phase.
REQ-008 SHALL have port: cycles_required  input  DATA_WIDTH  number of full square-wave periods to emit.
REQ-009 SHALL have port: out_wave  output  1  registered generated square wave, loop-back stimulus for the team's frequency counter.
REQ-010 SHALL have port: busy  output  1  high while in HIGH or LOW state.
REQ-011 SHALL have port: done_flag  output  1  high while in DONE state.
REQ-012 SHALL have port: cycles_emitted  output  DATA_WIDTH  count of completed periods in current/last burst.

Function
REQ-013 SHALL implement FSM with states IDLE, HIGH, LOW, DONE; all transitions qualified by enable=1.
REQ-014 IDLE: on start=1, SHALL latch half_period and cycles_required into internal registers and clear cycles_emitted to 0.
REQ-015 IDLE + start with latched half_period=0 or cycles_required=0 SHALL go directly to DONE; out_wave stays 0, cycles_emitted=0.
REQ-016 IDLE + start with both nonzero SHALL go to HIGH; out_wave=1 from the first cycle after the sampling edge.
REQ-017 HIGH SHALL last exactly latched half_period enabled cycles with out_wave=1, then go to LOW.
REQ-018 LOW SHALL last exactly latched half_period enabled cycles with out_wave=0; on its final cycle cycles_emitted SHALL increment by 1.
REQ-019 End of LOW: if incremented cycles_emitted equals latched cycles_required SHALL go to DONE, else to HIGH.
REQ-020 Output period SHALL be exactly 2*half_period Clock cycles at 50% duty; burst SHALL contain exactly cycles_required rising edges of out_wave.
REQ-021 Changes to half_period/cycles_required outside IDLE SHALL be ignored until the next burst.
REQ-022 Phase counter SHALL be DATA_WIDTH bits, count 0..half_period-1, never wrap; half_period=2^DATA_WIDTH-1 SHALL be supported.
REQ-023 cycles_emitted SHALL saturate at cycles_required, never wrap.
REQ-024 DONE: out_wave=0, done_flag=1, cycles_emitted held; SHALL go to IDLE when start=0 (done_flag clears that edge); start held high SHALL NOT retrigger.
REQ-025 abort=1 in HIGH or LOW SHALL go to IDLE next edge: out_wave=0, done_flag stays 0, cycles_emitted holds partial count.
REQ-026 abort has priority over phase completion on the same edge; abort in IDLE or DONE SHALL have no effect.
REQ-027 enable=0 mid-phase SHALL freeze the phase counter and out_wave level; the phase resumes with remaining cycles unchanged.
REQ-028 busy and done_flag SHALL be registered state decodes, never both high.

Reset
REQ-029 nReset low SHALL immediately force: state IDLE, out_wave=0, busy=0, done_flag=0, cycles_emitted=0, phase counter and latched registers 0.
REQ-030 Reset asserted mid-burst SHALL abort with no glitch beyond the immediate drop of out_wave to 0; first post-reset burst needs a fresh start.

Verification
REQ-031 half_period=3, cycles_required=4, start pulse -> out_wave 1,1,1,0,0,0 x4 (24 cycles), cycles_emitted steps 1..4, done_flag=1 on cycle 25.
REQ-032 half_period=0, cycles_required=5 -> DONE next edge, out_wave never high, cycles_emitted=0; same for half_period=2, cycles_required=0.
REQ-033 half_period=4, cycles_required=10, abort during 3rd HIGH -> IDLE next edge, out_wave=0, cycles_emitted=2, done_flag=0.
REQ-034 half_period=5, enable low for 7 cycles during 2nd HIGH -> high phase stretches to 12 cycles, all other phases exactly 5.
REQ-035 start held high through DONE -> no second burst; start dropped 1 cycle -> IDLE, done_flag=0; reassert -> new burst.
REQ-036 nReset pulsed mid-LOW with cycles_emitted=3 -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/freq_generator.sv
// rtl/freq_generator.sv - burst square-wave generator with abort, clock-enable and saturating period count
module freq_generator #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] half_period,
  input  logic [DATA_WIDTH-1:0] cycles_required,
  output logic                  out_wave,
  output logic                  busy,
  output logic                  done_flag,
  output logic [DATA_WIDTH-1:0] cycles_emitted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] phase_q, phase_d;
  logic [DATA_WIDTH-1:0] hp_q, hp_d;
  logic [DATA_WIDTH-1:0] cr_q, cr_d;
  logic [DATA_WIDTH-1:0] emitted_q, emitted_d;
  logic                  out_wave_q, out_wave_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  phase_last;
  logic [DATA_WIDTH-1:0] emitted_inc;

  // Phase ends when the counter reaches half_period-1; the counter never
  // exceeds that value, so it cannot wrap even at the all-ones half period.
  // The period count saturates at the latched target.
  always_comb begin
    phase_last  = (phase_q == (hp_q - ONE));
    emitted_inc = (emitted_q < cr_q) ? (emitted_q + ONE) : emitted_q;
  end

  // Next-state logic; nothing moves while enable is low. Abort is checked
  // before phase completion so it wins on a coinciding edge.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    hp_d      = hp_q;
    cr_d      = cr_q;
    emitted_d = emitted_q;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            hp_d      = half_period;
            cr_d      = cycles_required;
            emitted_d = ZERO;
            phase_d   = ZERO;
            if ((half_period == ZERO) || (cycles_required == ZERO)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_HIGH;
            end
          end
        end
        S_HIGH: begin
          if (abort) begin
            state_d = S_IDLE;
            phase_d = ZERO;
          end else if (phase_last) begin
            state_d = S_LOW;
            phase_d = ZERO;
          end else begin
            phase_d = phase_q + ONE;
          end
        end
        S_LOW: begin
          if (abort) begin
            state_d = S_IDLE;
            phase_d = ZERO;
          end else if (phase_last) begin
            emitted_d = emitted_inc;
            phase_d   = ZERO;
            state_d   = (emitted_inc == cr_q) ? S_DONE : S_HIGH;
          end else begin
            phase_d = phase_q + ONE;
          end
        end
        S_DONE: begin
          if (!start) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are registered decodes of the next state, so they line up with
  // the state register and busy/done_flag can never be high together.
  always_comb begin
    out_wave_d = (state_d == S_HIGH);
    busy_d     = (state_d == S_HIGH) || (state_d == S_LOW);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      hp_q       <= '0;
      cr_q       <= '0;
      emitted_q  <= '0;
      out_wave_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hp_q       <= hp_d;
      cr_q       <= cr_d;
      emitted_q  <= emitted_d;
      out_wave_q <= out_wave_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign out_wave       = out_wave_q;
  assign busy           = busy_q;
  assign done_flag      = done_q;
  assign cycles_emitted = emitted_q;

endmodule

// File: tb/tb_freq_generator.sv
// tb/tb_freq_generator.sv - self-checking bench for freq_generator
module tb_freq_generator;

  localparam int W = 8;

  logic         Clock;
  logic         nReset;
  logic         enable;
  logic         start;
  logic         abort;
  logic [W-1:0] half_period;
  logic [W-1:0] cycles_required;
  logic         out_wave;
  logic         busy;
  logic         done_flag;
  logic [W-1:0] cycles_emitted;

  int total = 0;
  int bad   = 0;

  freq_generator #(.DATA_WIDTH(W)) dut (
    .Clock          (Clock),
    .nReset         (nReset),
    .enable         (enable),
    .start          (start),
    .abort          (abort),
    .half_period    (half_period),
    .cycles_required(cycles_required),
    .out_wave       (out_wave),
    .busy           (busy),
    .done_flag      (done_flag),
    .cycles_emitted (cycles_emitted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: a burst is a sequence of 2*hp*cr enabled cycles,
  // position pos gives level and completed periods arithmetically.
  int m_mode;   // 0 idle, 1 running, 2 done
  int m_pos;
  int m_hp;
  int m_cr;
  int m_emit;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_hp = 0; m_cr = 0; m_emit = 0;
  endtask

  task automatic model_update();
    if (nReset && enable) begin
      case (m_mode)
        0: if (start) begin
          m_hp = int'(half_period);
          m_cr = int'(cycles_required);
          m_pos = 0;
          m_emit = 0;
          m_mode = (m_hp == 0 || m_cr == 0) ? 2 : 1;
        end
        1: begin
          if (abort) begin
            m_emit = m_pos / (2 * m_hp);
            m_mode = 0;
          end else begin
            m_pos = m_pos + 1;
            if (m_pos == 2 * m_hp * m_cr) begin
              m_emit = m_cr;
              m_mode = 2;
            end
          end
        end
        default: if (!start) m_mode = 0;
      endcase
    end
  endtask

  function automatic int exp_out();
    return (m_mode == 1 && (m_pos % (2 * m_hp)) < m_hp) ? 1 : 0;
  endfunction

  function automatic int exp_emit();
    return (m_mode == 1) ? m_pos / (2 * m_hp) : m_emit;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    model_reset();
    @(posedge Clock);
    @(posedge Clock);
    #1;
    nReset = 1'b1;
  endtask

  typedef struct {
    int hp;
    int cr;
    int exp_rises;
    int exp_emit;
    int exp_n;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, rises, prev, cnt, level, len;
    int runs[$];
    int exp_runs[$];

    vecs[0] = '{3, 4, 4, 4, 25};
    vecs[1] = '{0, 5, 0, 0, 1};
    vecs[2] = '{2, 0, 0, 0, 1};
    vecs[3] = '{1, 1, 1, 1, 3};
    vecs[4] = '{1, 3, 3, 3, 7};
    vecs[5] = '{7, 2, 2, 2, 29};
    vecs[6] = '{255, 1, 1, 1, 511};
    vecs[7] = '{1, 255, 255, 255, 511};

    enable = 1'b1; start = 1'b0; abort = 1'b0;
    half_period = '0; cycles_required = '0;
    nReset = 1'b0;
    model_reset();
    #3;
    chk("reset_out_wave", int'(out_wave), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done_flag), 0);
    chk("reset_emitted", int'(cycles_emitted), 0);
    do_reset();

    // Table-driven bursts: rising edges, final count, cycles to done
    for (int i = 0; i < 8; i++) begin
      half_period = W'(vecs[i].hp);
      cycles_required = W'(vecs[i].cr);
      start = 1'b1;
      n = 0; rises = 0; prev = 0;
      while (n < 2000) begin
        tick();
        start = 1'b0;
        n++;
        if (out_wave && prev == 0) rises++;
        prev = int'(out_wave);
        if (done_flag) break;
      end
      chk($sformatf("vec%0d_cycles_to_done", i), n, vecs[i].exp_n);
      chk($sformatf("vec%0d_rises", i), rises, vecs[i].exp_rises);
      chk($sformatf("vec%0d_emitted", i), int'(cycles_emitted), vecs[i].exp_emit);
      chk($sformatf("vec%0d_done_out_low", i), int'(out_wave), 0);
      tick();
      chk($sformatf("vec%0d_done_clears", i), int'(done_flag), 0);
      chk($sformatf("vec%0d_emitted_held", i), int'(cycles_emitted), vecs[i].exp_emit);
    end

    // Abort during the third high phase; later inputs are ignored mid-burst
    half_period = 8'd4; cycles_required = 8'd10; start = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      start = 1'b0;
      half_period = 8'd1;
      cycles_required = 8'd1;
    end
    chk("abort_pre_out", int'(out_wave), 1);
    chk("abort_pre_emit", int'(cycles_emitted), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_out", int'(out_wave), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done_flag), 0);
    chk("abort_emit", int'(cycles_emitted), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_noeffect", int'(cycles_emitted), 2);

    // Enable low for 7 cycles in the second high phase stretches it to 12
    half_period = 8'd5; cycles_required = 8'd2; start = 1'b1;
    cnt = 0; level = 1; len = 0;
    runs.delete();
    while (cnt < 200) begin
      enable = (cnt >= 12 && cnt < 19) ? 1'b0 : 1'b1;
      tick();
      start = 1'b0;
      cnt++;
      if (done_flag) break;
      if (int'(out_wave) == level) len++;
      else begin
        runs.push_back(len);
        level = int'(out_wave);
        len = 1;
      end
    end
    runs.push_back(len);
    enable = 1'b1;
    exp_runs = '{5, 5, 12, 5};
    chk("stretch_run_count", runs.size(), exp_runs.size());
    for (int i = 0; i < 4 && i < runs.size(); i++)
      chk($sformatf("stretch_run%0d", i), runs[i], exp_runs[i]);
    tick();

    // Start held through DONE does not retrigger; a one-cycle drop does
    half_period = 8'd1; cycles_required = 8'd1; start = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("hold_done", int'(done_flag), 1);
    chk("hold_no_busy", int'(busy), 0);
    start = 1'b0;
    tick();
    chk("drop_done_clear", int'(done_flag), 0);
    start = 1'b1;
    tick();
    chk("retrigger_busy", int'(busy), 1);
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    tick();

    // Reset pulsed in the low phase of the fourth period
    half_period = 8'd2; cycles_required = 8'd5; start = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      start = 1'b0;
    end
    chk("prereset_emit", int'(cycles_emitted), 3);
    chk("prereset_low", int'(out_wave), 0);
    chk("prereset_busy", int'(busy), 1);
    #2;
    nReset = 1'b0;
    model_reset();
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_emit", int'(cycles_emitted), 0);
    @(posedge Clock);
    #1;
    nReset = 1'b1;
    tick();
    tick();
    chk("postreset_idle", int'(busy), 0);
    chk("postreset_out", int'(out_wave), 0);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      enable = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
      start = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      abort = ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0;
      half_period = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 4));
      cycles_required = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 3));
      tick();
      chk("rnd_out", int'(out_wave), exp_out());
      chk("rnd_busy", int'(busy), (m_mode == 1) ? 1 : 0);
      chk("rnd_done", int'(done_flag), (m_mode == 2) ? 1 : 0);
      chk("rnd_emit", int'(cycles_emitted), exp_emit());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
